// File: rtl/tc_register_file.sv
`default_nettype none
// ============================================================================
// Module   : tc_register_file
// Purpose  : Multi-entry register bank for the counter datapath. Holds DEPTH
//            words of BIT_WIDTH bits. It has one write port, two independent
//            gated read ports with registered outputs, an optional
//            write-to-read bypass and a synchronous clear of the whole bank.
// Ports    : clk                - rising-edge clock
//            rst                - asynchronous reset, active low
//            clear              - synchronous clear of all entries (beats save)
//            save / save_addr   - write enable / write address
//            in                 - write data
//            load_a / addr_a    - read enable / address, port A
//            out_a              - registered read data, port A (0 when unloaded)
//            load_b / addr_b    - read enable / address, port B
//            out_b              - registered read data, port B (0 when unloaded)
// Revision : 1.0 - initial release
// ============================================================================
module tc_register_file #(
  parameter int   BIT_WIDTH = 8,
  parameter int   DEPTH     = 4,
  parameter bit   BYPASS    = 1'b0,
  localparam int  AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 save,
  input  logic [AW-1:0]        save_addr,
  input  logic [BIT_WIDTH-1:0] in,
  input  logic                 load_a,
  input  logic [AW-1:0]        addr_a,
  output logic [BIT_WIDTH-1:0] out_a,
  input  logic                 load_b,
  input  logic [AW-1:0]        addr_b,
  output logic [BIT_WIDTH-1:0] out_b
);

  // One extra bit so that DEPTH = 2**AW (e.g. 256) is still representable.
  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

  logic [BIT_WIDTH-1:0] entry_q [DEPTH];
  logic [BIT_WIDTH-1:0] out_a_q, out_a_d;
  logic [BIT_WIDTH-1:0] out_b_q, out_b_d;
  logic                 save_ok;

  // Writes to addresses beyond DEPTH are silently dropped.
  assign save_ok = save && ({1'b0, save_addr} < C_DEPTH);

  // Read-value selection shared by both ports.
  function automatic logic [BIT_WIDTH-1:0] f_read(input logic          ld,
                                                  input logic [AW-1:0] addr);
    logic [BIT_WIDTH-1:0] val;
    val = '0;
    if (ld && ({1'b0, addr} < C_DEPTH)) begin
      if (BYPASS && clear) begin
        val = '0;
      end else if (BYPASS && save_ok && (save_addr == addr)) begin
        val = in;
      end else begin
        val = entry_q[addr];
      end
    end
    return val;
  endfunction

  always_comb begin
    out_a_d = '0;
    out_b_d = '0;
    out_a_d = f_read(load_a, addr_a);
    out_b_d = f_read(load_b, addr_b);
  end

  // Storage: clear wins over save. Comparing each entry index against the
  // write address means an out-of-range address matches nothing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (clear) begin
          entry_q[i] <= '0;
        end else if (save_ok && (save_addr == AW'(i))) begin
          entry_q[i] <= in;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_a_q <= '0;
      out_b_q <= '0;
    end else begin
      out_a_q <= out_a_d;
      out_b_q <= out_b_d;
    end
  end

  assign out_a = out_a_q;
  assign out_b = out_b_q;

endmodule
`default_nettype wire

// File: tb/tb_tc_register_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_tc_register_file
// Purpose  : Self-checking bench for tc_register_file. Three instances share
//            one stimulus stream: u0 (DEPTH=4, no bypass), u1 (DEPTH=4,
//            bypass), u2 (DEPTH=3, no bypass). A behavioural model predicts
//            every output. Literal expectations pin the directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tc_register_file;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear, save, load_a, load_b;
  logic [1:0] save_addr, addr_a, addr_b;
  logic [7:0] din;
  logic [7:0] oa0, ob0, oa1, ob1, oa2, ob2;

  int tests  = 0;
  int fails  = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  tc_register_file #(.BIT_WIDTH(8), .DEPTH(4), .BYPASS(1'b0)) u0 (
    .clk(clk), .rst(rst), .clear(clear), .save(save), .save_addr(save_addr),
    .in(din), .load_a(load_a), .addr_a(addr_a), .out_a(oa0),
    .load_b(load_b), .addr_b(addr_b), .out_b(ob0));

  tc_register_file #(.BIT_WIDTH(8), .DEPTH(4), .BYPASS(1'b1)) u1 (
    .clk(clk), .rst(rst), .clear(clear), .save(save), .save_addr(save_addr),
    .in(din), .load_a(load_a), .addr_a(addr_a), .out_a(oa1),
    .load_b(load_b), .addr_b(addr_b), .out_b(ob1));

  tc_register_file #(.BIT_WIDTH(8), .DEPTH(3), .BYPASS(1'b0)) u2 (
    .clk(clk), .rst(rst), .clear(clear), .save(save), .save_addr(save_addr),
    .in(din), .load_a(load_a), .addr_a(addr_a), .out_a(oa2),
    .load_b(load_b), .addr_b(addr_b), .out_b(ob2));

  // ---------------- behavioural model ----------------
  logic [7:0] m_mem [3][4];
  int         m_depth [3] = '{4, 4, 3};
  bit         m_byp   [3] = '{1'b0, 1'b1, 1'b0};
  logic [7:0] e_a [3];
  logic [7:0] e_b [3];

  function automatic logic [7:0] mread(int k, logic ld, logic [1:0] a);
    if (!ld || int'(a) >= m_depth[k]) return 8'h00;
    if (m_byp[k]) begin
      if (clear) return 8'h00;
      if (save && a == save_addr) return din;
    end
    return m_mem[k][a];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 4; j++) m_mem[k][j] = 8'h00;
      e_a[k] = 8'h00;
      e_b[k] = 8'h00;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      e_a[k] = mread(k, load_a, addr_a);
      e_b[k] = mread(k, load_b, addr_b);
      if (clear) begin
        for (int j = 0; j < 4; j++) m_mem[k][j] = 8'h00;
      end else if (save && int'(save_addr) < m_depth[k]) begin
        m_mem[k][save_addr] = din;
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %02h expected %02h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] get_a(int k);
    case (k)
      0: return oa0;
      1: return oa1;
      default: return oa2;
    endcase
  endfunction

  function automatic logic [7:0] get_b(int k);
    case (k)
      0: return ob0;
      1: return ob1;
      default: return ob2;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("u%0d_out_a", k), get_a(k), e_a[k]);
        chk($sformatf("u%0d_out_b", k), get_b(k), e_b[k]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Model sees exactly the inputs the DUT sampled; returns #1 after the edge.
  task automatic cycle();
    @(posedge clk);
    if (rst) model_step();
    #1;
  endtask

  task automatic wr(logic [1:0] a, logic [7:0] d);
    save = 1'b1; save_addr = a; din = d;
    cycle();
    save = 1'b0;
  endtask

  task automatic rd(logic la, logic [1:0] aa, logic lb, logic [1:0] ab);
    load_a = la; addr_a = aa; load_b = lb; addr_b = ab;
    cycle();
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; save = 1'b0; load_a = 1'b0; load_b = 1'b0;
    save_addr = 2'd0; addr_a = 2'd0; addr_b = 2'd0; din = 8'h00;
    #1 rst = 1'b0;
    model_reset();
    chk_en = 1'b1;
    #12 rst = 1'b1;

    // Reset: fill with A5, read it, then assert rst between edges.
    for (int i = 0; i < 4; i++) wr(2'(i), 8'hA5);
    rd(1'b1, 2'd2, 1'b1, 2'd0);
    chk("pre_rst_a", oa0, 8'hA5);
    chk("pre_rst_b", ob0, 8'hA5);
    #3 rst = 1'b0;
    model_reset();
    #1;
    chk("async_rst_a", oa0, 8'h00);
    chk("async_rst_b", ob0, 8'h00);
    @(negedge clk);
    #2 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd(1'b1, 2'(i), 1'b1, 2'(i));
      chk("post_rst_a", oa0, 8'h00);
      chk("post_rst_b", ob0, 8'h00);
    end

    // Write / read.
    load_a = 1'b0; load_b = 1'b0;
    wr(2'd0, 8'h11); wr(2'd1, 8'h22); wr(2'd2, 8'h33); wr(2'd3, 8'h44);
    rd(1'b1, 2'd2, 1'b1, 2'd3);
    chk("rd_a_addr2", oa0, 8'h33);
    chk("rd_b_addr3", ob0, 8'h44);
    rd(1'b0, 2'd2, 1'b1, 2'd3);
    chk("unload_a", oa0, 8'h00);
    chk("hold_b", ob0, 8'h44);

    // Same-cycle write/read at address 1.
    load_a = 1'b1; addr_a = 2'd1; load_b = 1'b0;
    wr(2'd1, 8'h99);
    chk("nobyp_same", oa0, 8'h22);
    chk("byp_same", oa1, 8'h99);
    chk("d3_same", oa2, 8'h22);
    rd(1'b1, 2'd1, 1'b0, 2'd0);
    chk("nobyp_next", oa0, 8'h99);

    // Dual port, same address.
    load_a = 1'b0;
    wr(2'd0, 8'h5C);
    rd(1'b1, 2'd0, 1'b1, 2'd0);
    chk("dual_a", oa0, 8'h5C);
    chk("dual_b", ob0, 8'h5C);

    // Out-of-range write and read on DEPTH=3.
    load_a = 1'b0; load_b = 1'b0;
    wr(2'd3, 8'hEE);
    rd(1'b1, 2'd3, 1'b1, 2'd2);
    chk("d3_oob_a", oa2, 8'h00);
    chk("d3_keep_b", ob2, 8'h33);
    chk("d4_addr3", oa0, 8'hEE);

    // Clear beats save.
    load_a = 1'b0; load_b = 1'b0;
    clear = 1'b1;
    wr(2'd0, 8'h77);
    clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd(1'b1, 2'(i), 1'b1, 2'(i));
      chk("clr_a", oa0, 8'h00);
      chk("clr_b", ob1, 8'h00);
    end

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      clear     = ($urandom_range(15) == 0);
      save      = $urandom_range(1);
      save_addr = 2'($urandom_range(3));
      din       = 8'($urandom);
      load_a    = ($urandom_range(3) != 0);
      addr_a    = 2'($urandom_range(3));
      load_b    = ($urandom_range(3) != 0);
      addr_b    = ($urandom_range(3) == 0) ? addr_a : 2'($urandom_range(3));
      if ($urandom_range(399) == 0) begin
        #2 rst = 1'b0;
        model_reset();
        @(negedge clk);
        #2 rst = 1'b1;
      end
      cycle();
    end

    @(negedge clk);
    #1 chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tc_register_file.md
# tc_register_file

Parametrised multi-entry register bank for the counter datapath, replacing chains of single-entry registers with one block. Holds DEPTH words of BIT_WIDTH bits, with one write port and two independent gated read ports. Each read output is registered and forced to zero when its port is not loaded. Optional write-to-read bypass and a synchronous bank clear are provided.

## Interface
- BIT_WIDTH, 8: width of each stored word.
- DEPTH, 4: number of entries; 1..256, need not be a power of two.
- BYPASS, 0: 0 = a read returns the pre-write contents; 1 = a read of the address being written in the same cycle returns the write data.
- AW, derived, not overridable: max(1, $clog2(DEPTH)).

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous clear of all entries.
- save  input  1  write enable.
- save_addr  input  AW  write address.
- in  input  BIT_WIDTH  write data.
- load_a  input  1  read enable, port A.
- addr_a  input  AW  read address, port A.
- out_a  output  BIT_WIDTH  registered read data, port A.
- load_b  input  1  read enable, port B.
- addr_b  input  AW  read address, port B.
- out_b  output  BIT_WIDTH  registered read data, port B.

## Operation
- Reset (rst low, asynchronous): all entries, out_a and out_b clear to 0 immediately. They stay 0 while rst is low. Inputs are ignored.
- Write: save=1 and save_addr<DEPTH writes in to entry[save_addr] at the clock edge. save_addr>=DEPTH: the write is dropped and no entry changes.
- Clear: clear=1 zeroes every entry at the edge. clear has priority over save; the save in that cycle is lost.
- Read, port A (port B identical and independent):
  - load_a=0: out_a <= 0.
  - load_a=1 and addr_a>=DEPTH: out_a <= 0.
  - load_a=1 and addr_a valid: out_a <= entry value selected by BYPASS rules.
- BYPASS=0: reads sample the entry contents as they are before this edge's write or clear.
- BYPASS=1:
  - If clear=1, a loaded read returns 0.
  - Otherwise, if save=1 and save_addr==addr_a with a valid address, it returns in.
  - Otherwise it returns the stored entry.
- Both ports may read the same address in the same cycle; both return the same value.
- No arithmetic on the data. Entries hold their value until written, cleared or reset.

## Timing
- Read latency is 1 cycle. Address and load presented before edge N appear on out_x after edge N and hold until edge N+1.
- Write latency is 1 cycle. Data saved at edge N is visible to a read sampled at edge N+1, so it appears on the output after N+1.
- BYPASS=1 reduces write-to-output latency to the same edge N.
- out_x changes only on a clk edge or on assertion of rst. No combinational input-to-output path exists.
- Reset deassertion is synchronised externally. The first active edge after rst rises behaves as a normal cycle.
- Reset mid-operation: a write in the same cycle as rst assertion is lost. The outputs read 0 until the first loaded read after release.

## Test plan
- Reset: write 0xA5 to every entry, assert rst asynchronously between edges -> out_a/out_b go 0 without a clock edge; loaded reads of all entries after release return 0.
- Write/read, BIT_WIDTH=8, DEPTH=4: save 0x11,0x22,0x33,0x44 to addresses 0..3, then load_a=1 on addr 2 and load_b=1 on addr 3 -> out_a=0x33, out_b=0x44 one cycle later; drop load_a -> out_a=0 the next cycle.
- Same-cycle write/read at address 1 holding 0x22, writing 0x99: BYPASS=0 -> out_a=0x22 that cycle, 0x99 on the next read. BYPASS=1 -> out_a=0x99 immediately.
- Clear vs save: clear=1 with save=1, addr 0, in=0x77 -> all entries read 0 afterwards, including addr 0.
- Non-power-of-two, DEPTH=3: save 0xEE to addr 3 -> entries 0..2 unchanged; load_a on addr 3 -> out_a=0.
- Dual port, same address: load_a=load_b=1 on addr 0 holding 0x5C -> out_a=out_b=0x5C.
